seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of the port-E popcount coprocessor result. Latches a 16-bit value
//  (popcount zero-extended, or any word the PIC32 side exposes) and drives the board's
//  12-pin 4-digit multiplexed 7-segment display. Shows hex digits with leading-zero blanking.
//  Updates without tearing and applies a ghost-suppression gap between digit slots.
// PARAMETERS
//  DIGIT_CYCLES  50000  clock cycles per digit slot (1 kHz slot rate at 50 MHz); must be >= 2
//  GHOST_CYCLES  16     cycles at slot start with all digits off; must be < DIGIT_CYCLES
//  BLANK_LZ      1      1 = blank leading zeros on digits 0..2; digit 3 is always shown
// PORTS
//  clock        in   1       single system clock
//  reset        in   1       asynchronous, active-high reset
//  value        in   16      word to display; [15:12] goes to digit 0 (leftmost)
//  value_valid  in   1       load strobe, sampled on rising clock
//  dp_mask      in   4       bit i lights the decimal point of digit i; live, not latched
//  blank        in   1       forces the display fully off while high
//  pending      out  1       a loaded value is waiting for the next frame boundary
//  display      out  [1:12]  [1:7] = segments a..g, [8] = dp, [9:12] = digit 0..3 enables;
//                            all pins active-low
// BEHAVIOUR
//  - Reset, asynchronous: slot counter = 0, digit index = 0, shown = 0, pend_val = 0,
//    pending = 0, display = 12'hFFF (all off).
//  - Slot counter runs 0..DIGIT_CYCLES-1, then wraps. On wrap, the digit index advances
//    0->1->2->3->0.
//  - Frame boundary: the cycle where the counter wraps and the index goes 3->0.
//  - Load: value_valid=1 captures value into pend_val and sets pending. A later load before
//    the boundary overwrites pend_val; the last load wins.
//  - At the boundary: shown <= value_valid ? value : pend_val (only if pending or value_valid).
//    pending clears; a same-cycle load goes straight to shown.
//  - Digit output when counter < GHOST_CYCLES, blank = 1, or the digit is blanked:
//    all 12 pins = 1.
//  - Digit output otherwise: that digit's enable = 0, the other enables = 1, segments =
//    hex font of the nibble, dp = ~dp_mask[i].
//  - Leading-zero blanking (BLANK_LZ = 1): digit i (i <= 2) is blanked when all nibbles
//    0..i of shown are 0. Digit 3 is never blanked.
//  - display is a registered output: it reflects the counter, index and shown of the
//    previous cycle (1-cycle latency).
//  - blank affects the output only. The counters keep running, and pending/shown updates
//    still occur.
//  - The hex font is the standard one: 0-9 and A, b, C, d, E, F.
//    '0' = abcdef; '1' = bc; '7' = abc; '8' = all seven.
//  - Reset mid-scan: immediate all-off, and the scan restarts at digit 0 with a ghost gap.
//    Any pending value is lost.
// STRUCTURE
//  - Shared package seg7_pkg:
//    - SEG_OFF / DIGIT_OFF constants (all ones)
//    - 16-entry hex font table as a 7-bit {a..g} active-high constant array
//    - N_DIGITS = 4
//  - Sub-module hex_to_seg7: combinational nibble -> 7-bit active-low segments; reused by
//    later display blocks.
//  - Top level holds the slot counter, digit index, pend_val/shown registers, blanking
//    logic and the output register.
// TESTING  (bench: DIGIT_CYCLES = 8, GHOST_CYCLES = 2, BLANK_LZ = 1)
//  1. Reset, then release.
//     -> display = 12'hFFF for slots 0..2 (shown = 0, so blanked) and for the ghost cycles.
//     -> Slot 3 from cycle 3*8+2+1 onward: 12'b0000001_1_1110 ('0' on digit 3).
//  2. value = 16'h1234 pulsed in slot 1.
//     -> pending = 1; the display keeps the old value until the boundary.
//     -> Next frame, slot 0: 12'b1001111_1_0111 ('1').
//     -> Slot 3: 12'b1001100_1_1110 ('4').
//  3. value = 16'h0040 loaded.
//     -> Slots 0 and 1 are all-off.
//     -> Slot 2 shows '4' (12'b1001100_1_1101).
//     -> Slot 3 shows '0'.
//  4. Load 16'hAAAA in slot 2, then 16'h5555 on the exact boundary cycle.
//     -> The next frame shows 5555; pending = 0 after the boundary.
//  5. dp_mask = 4'b0100, then blank = 1 for 5 cycles in slot 2.
//     -> During blank: display = 12'hFFF one cycle after blank rises.
//     -> After blank drops: the scan continues in phase (no counter reset), dp pin = 0 on
//        digit 2 only.
//  6. Assert reset for 1 cycle mid-slot with pending = 1.
//     -> display = 12'hFFF immediately (asynchronous); pending = 0; shown = 0.
//     -> The scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks: pin "off" levels and the hex font.
// Latency: none (package only).
// Backpressure: none.
package seg7_pkg;

    localparam int N_DIGITS = 4;

    // Display pins are active-low, so "off" is all ones.
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] DIGIT_OFF = 4'hF;

    // Hex font, active-high, bit order {a,b,c,d,e,f,g} (a is bit 6).
    localparam logic [6:0] HEX_FONT [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: load value/strobe, dp and blank controls, pending flag, 12 display pins.
// Latency: n/a (wires only).
// Backpressure: none; value_valid is a fire-and-forget strobe, pending reports an unapplied load.
interface seg7_scan_driver_if;
    logic [15:0] value;        // word to display, [15:12] -> digit 0 (leftmost)
    logic        value_valid;  // load strobe
    logic [3:0]  dp_mask;      // bit i lights dp of digit i (live)
    logic        blank;        // forces display off while high
    logic        pending;      // loaded value waiting for the frame boundary
    logic [1:12] display;      // [1:7] seg a..g, [8] dp, [9:12] digit 0..3 enables; active-low

    modport master (
        output value, value_valid, dp_mask, blank,
        input  pending, display
    );

    modport slave (
        input  value, value_valid, dp_mask, blank,
        output pending, display
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment pattern {a..g}; ports: nibble in, seg_n out.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = ~HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit hex display driver with tear-free frame-aligned updates, leading-zero
// blanking and a ghost-suppression gap. Ports: clock, reset (async, active-high), bus (slave).
// Latency: display is registered, 1 cycle behind counter/index/shown. Backpressure: none.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int GHOST_CYCLES = 16,
    parameter int BLANK_LZ     = 1
) (
    input  logic          clock,
    input  logic          reset,
    seg7_scan_driver_if.slave bus
);

    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = $clog2(N_DIGITS);

    logic [CW-1:0] slot_cnt;
    logic [IW-1:0] digit_idx;
    logic [15:0]   pend_val;
    logic [15:0]   shown;
    logic          pending_q;
    logic [1:12]   display_q;

    logic          slot_wrap;
    logic          frame_end;
    logic [3:0]    nibble;
    logic          lz_zero;
    logic [6:0]    seg_n;
    logic [3:0]    dig_en_n;
    logic          digit_off;
    logic [1:12]   display_d;

    assign slot_wrap = (slot_cnt == CW'(DIGIT_CYCLES - 1));
    assign frame_end = slot_wrap && (digit_idx == IW'(N_DIGITS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            pend_val  <= '0;
            shown     <= '0;
            pending_q <= 1'b0;
            display_q <= {SEG_OFF, 1'b1, DIGIT_OFF};
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= digit_idx + 1'b1;
            end

            if (bus.value_valid) begin
                pend_val <= bus.value;
            end

            // Shown only changes at the frame boundary so a frame never mixes two words;
            // a load on the boundary cycle itself bypasses pend_val.
            if (frame_end) begin
                if (bus.value_valid) begin
                    shown <= bus.value;
                end else if (pending_q) begin
                    shown <= pend_val;
                end
                pending_q <= 1'b0;
            end else if (bus.value_valid) begin
                pending_q <= 1'b1;
            end

            display_q <= display_d;
        end
    end

    // Digit i is a leading zero when nibbles 0..i of shown are all zero.
    always_comb begin
        nibble  = 4'h0;
        lz_zero = 1'b0;
        case (digit_idx)
            2'd0: begin nibble = shown[15:12]; lz_zero = (shown[15:12] == 4'h0); end
            2'd1: begin nibble = shown[11:8];  lz_zero = (shown[15:8]  == 8'h00); end
            2'd2: begin nibble = shown[7:4];   lz_zero = (shown[15:4]  == 12'h000); end
            default: begin nibble = shown[3:0]; lz_zero = 1'b0; end
        endcase
    end

    hex_to_seg7 u_font (
        .nibble (nibble),
        .seg_n  (seg_n)
    );

    always_comb begin
        dig_en_n  = ~(4'b1000 >> digit_idx);
        digit_off = (slot_cnt < CW'(GHOST_CYCLES)) || bus.blank || ((BLANK_LZ != 0) && lz_zero);
        display_d = {SEG_OFF, 1'b1, DIGIT_OFF};
        if (!digit_off) begin
            display_d = {seg_n, ~bus.dp_mask[digit_idx], dig_en_n};
        end
    end

    assign bus.pending = pending_q;
    assign bus.display = display_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int D = 8;
    localparam int G = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .DIGIT_CYCLES (D),
        .GHOST_CYCLES (G),
        .BLANK_LZ     (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference font, active-high {a..g}
    logic [6:0] font [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Model: k = clock edges since reset released
    int          k;
    logic [15:0] m_shown;
    logic [15:0] m_pend;
    logic        m_pending;

    function automatic logic [11:0] exp_disp(int kk, logic [15:0] sh, logic [3:0] dp, logic bl);
        int slot;
        int d;
        logic [15:0] upper;
        logic [3:0]  en;
        slot  = kk % D;
        d     = (kk / D) % 4;
        upper = sh >> (4 * (3 - d));     // nibbles 0..d of the shown word
        if (slot < G || bl) return 12'hFFF;
        if (d < 3 && upper == 16'h0) return 12'hFFF;
        en = 4'b1111;
        en[3 - d] = 1'b0;
        return {~font[upper[3:0]], ~dp[d], en};
    endfunction

    task automatic chk(string tag, logic [15:0] got, logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        k = 0; m_shown = 16'h0; m_pend = 16'h0; m_pending = 1'b0;
    endtask

    task automatic tick();
        logic [11:0] e;
        logic        vv;
        logic [15:0] v;
        bit          boundary;
        e  = exp_disp(k, m_shown, bus.dp_mask, bus.blank);
        vv = bus.value_valid;
        v  = bus.value;
        boundary = ((k % D) == D - 1) && (((k / D) % 4) == 3);
        @(posedge clock);
        #1;
        if (boundary) begin
            if (vv) m_shown = v;
            else if (m_pending) m_shown = m_pend;
            m_pending = 1'b0;
        end else if (vv) begin
            m_pending = 1'b1;
        end
        if (vv) m_pend = v;
        k++;
        chk("display", 16'(bus.display), 16'(e));
        chk("pending", 16'(bus.pending), 16'(m_pending));
    endtask

    task automatic run_to(int d, int c);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if ((k % D) == c && ((k / D) % 4) == d) found = 1'b1;
            else tick();
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL run_to timeout digit=%0d cnt=%0d", d, c);
        end
    endtask

    task automatic show_at(int d, int c, logic [11:0] want, string tag);
        run_to(d, c);
        tick();
        chk(tag, 16'(bus.display), 16'(want));
    endtask

    initial begin
        bus.value = 16'h0; bus.value_valid = 1'b0; bus.dp_mask = 4'h0; bus.blank = 1'b0;
        model_reset();

        // 1. reset state and idle scan of zero
        #1 reset = 1'b1;
        #1;
        chk("rst_display", 16'(bus.display), 16'hFFF);
        chk("rst_pending", 16'(bus.pending), 16'h0);
        @(posedge clock); #1 reset = 1'b0;
        show_at(0, 5, 12'hFFF, "t1_slot0_blank");
        show_at(3, 1, 12'hFFF, "t1_slot3_ghost");
        show_at(3, 2, 12'b0000001_1_1110, "t1_slot3_zero");

        // 2. load 1234 in slot 1
        run_to(1, 4);
        bus.value = 16'h1234; bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        chk("t2_pending", 16'(bus.pending), 16'h1);
        show_at(3, 3, 12'b0000001_1_1110, "t2_old_value");
        show_at(0, 3, 12'b1001111_1_0111, "t2_digit0_one");
        show_at(3, 3, 12'b1001100_1_1110, "t2_digit3_four");

        // 3. load 0040
        run_to(1, 0);
        bus.value = 16'h0040; bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        run_to(3, 7);
        tick();
        show_at(0, 4, 12'hFFF, "t3_d0_off");
        show_at(1, 4, 12'hFFF, "t3_d1_off");
        show_at(2, 4, 12'b1001100_1_1101, "t3_d2_four");
        show_at(3, 4, 12'b0000001_1_1110, "t3_d3_zero");

        // 4. AAAA in slot 2, then 5555 on the boundary cycle
        run_to(2, 3);
        bus.value = 16'hAAAA; bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        run_to(3, 7);
        bus.value = 16'h5555; bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        chk("t4_pending_clear", 16'(bus.pending), 16'h0);
        show_at(0, 4, 12'b0100100_1_0111, "t4_five");

        // 5. dp on digit 2, blank pulse in slot 2
        bus.dp_mask = 4'b0100;
        run_to(2, 3);
        bus.blank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_blank", 16'(bus.display), 16'hFFF);
        end
        bus.blank = 1'b0;
        show_at(2, 4, 12'b0100100_0_1101, "t5_dp_d2");
        show_at(3, 4, 12'b0100100_1_1110, "t5_no_dp_d3");

        // 6. async reset mid-slot with a pending load
        run_to(1, 3);
        bus.value = 16'h9999; bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        chk("t6_pending_set", 16'(bus.pending), 16'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_display", 16'(bus.display), 16'hFFF);
        chk("t6_rst_pending", 16'(bus.pending), 16'h0);
        model_reset();
        @(posedge clock); #1 reset = 1'b0;
        show_at(0, 1, 12'hFFF, "t6_restart_ghost");
        show_at(3, 2, 12'b0000001_1_1110, "t6_shown_zero");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] rv;
            rv = 16'($urandom);
            bus.value       = rv >> (4 * $urandom_range(0, 4));
            bus.value_valid = ($urandom_range(0, 19) == 0);
            bus.blank       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) bus.dp_mask = 4'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
